bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Bus control unit arbiter for the v30mz core. It shares the single 16-bit external memory bus between two requesters: the prefetch path (opcode fetch into the prefetch queue) and the execution unit (operand read/write). It sequences each bus cycle against the `readyb` handshake and drives address, byte enables and `bus_status`. It splits unaligned execution-unit word accesses into two byte cycles and discards prefetch data made stale by a queue flush.

## Interface
Parameters:
- `ADDR_W`, default 20: physical address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `pf_req`  in  1  prefetch wants a code fetch.
- `pf_addr`  in  ADDR_W  fetch address (PS*16+PFP).
- `pf_done`  out  1  one-cycle pulse; `pf_data` valid.
- `pf_data`  out  16  fetched code; lanes as on bus.
- `pf_byte`  out  1  with `pf_done`: only high lane valid (odd address).
- `flush`  in  1  queue flush; discard in-flight fetch.
- `eu_cmd`  in  2  IDLE=0, READ=1, WRITE=2; held until `eu_done`.
- `eu_addr`  in  ADDR_W  operand address.
- `eu_word`  in  1  1=word, 0=byte.
- `eu_wdata`  in  16  write data; byte in [7:0].
- `eu_done`  out  1  one-cycle pulse; access complete.
- `eu_rdata`  out  16  read data, right-justified; valid with `eu_done`.
- `address_out`  out  ADDR_W  bus address.
- `bus_ben`  out  2  byte enables: [0]=even lane [7:0], [1]=odd lane [15:8].
- `data_out`  out  16  lane-aligned write data.
- `data_in`  in  16  bus read data.
- `readyb`  in  1  active-low; cycle ends in the clock it is sampled low.
- `bus_status`  out  4  IDLE 4'hF, FETCH 4'b1000, READ 4'b1001, WRITE 4'b1010.

## Operation
- States: IDLE, PF_CYC, EU_CYC, EU_HI (second half of split word).
- IDLE arbitration:
  - `eu_cmd`!=IDLE has priority: go to EU_CYC.
  - Otherwise, `pf_req` and not `flush`: go to PF_CYC.
  - A started cycle is never preempted.
- PF_CYC:
  - Even `pf_addr`: `bus_ben`=2'b11.
  - Odd `pf_addr`: `bus_ben`=2'b10 and `pf_byte`=1.
- EU_CYC address handling:
  - Byte access: `bus_ben` selects the lane from addr[0]. Write byte is replicated on both lanes. Read byte is taken from the addressed lane into [7:0].
  - Even word: one cycle, `bus_ben`=2'b11.
  - Odd word: EU_CYC is a byte cycle at addr (odd lane); its low result is latched. EU_HI is a byte cycle at addr+1 (even lane), with high data on [7:0].
- On `readyb` low: latch data. Return to IDLE, or go to EU_HI for an odd word. The next clock pulses the matching done.
- Flush:
  - `flush` during PF_CYC, or in the cycle its done would pulse, sets `discard`.
  - The bus cycle still completes, but `pf_done` is suppressed.
  - `discard` clears on return to IDLE.
- Address arithmetic: addr+1 wraps modulo 2^ADDR_W (FFFFF+1 -> 00000).

## Timing
- Reset values:
  - state IDLE, `bus_status` 4'hF.
  - `address_out`, `bus_ben`, `data_out` all 0.
  - `pf_done`, `eu_done`, `pf_byte` 0; `pf_data`, `eu_rdata` 0; `discard` 0.
- Reset mid-cycle aborts immediately; no done pulse is generated.
- `address_out`, `bus_ben`, `bus_status` and `data_out` are registered. They change on the clock the state is entered and hold until `readyb` is sampled low.
- In IDLE, `bus_status`=4'hF and `bus_ben`=0.
- Minimum latency: request seen in IDLE at cycle N, bus cycle at N+1, `readyb` low at N+1, done at N+2.
- Odd word: done at N+3 minimum. Each `readyb` high cycle adds one.
- Back-to-back: IDLE re-arbitrates in the clock done pulses, so bus cycles are separated by exactly one IDLE clock.
- Simultaneous `pf_req` and `eu_cmd` in IDLE: EU wins, and prefetch waits.

## Structure
- Package `v30mz_pkg`: `bus_command_t` (IDLE/READ/WRITE), `bus_status_t` constants (BS_IDLE, BS_FETCH, BS_READ, BS_WRITE), `bau_state_t`.
- One sub-module is natural: `bus_lane_steer`, a combinational lane select / replicate / right-justify, shared by read and write paths.

## Test plan
- Reset, then idle → `bus_status`=4'hF, `bus_ben`=0, all dones 0.
- `pf_req`, `pf_addr`=FFFF0, `readyb` low immediately, `data_in`=0xEA90 → `address_out`=FFFF0, status 4'b1000, `bus_ben`=11, `pf_done` next clock with `pf_data`=0xEA90.
- Simultaneous `pf_req` and EU READ word at 0x00100 → EU cycle first; `eu_rdata`=`data_in`; fetch starts one IDLE clock after `eu_done`.
- EU WRITE word 0x1234 at 0x00201, `readyb` low in each cycle:
  - first cycle: `address_out`=0x00201, `bus_ben`=10, `data_out`[15:8]=0x34;
  - second cycle: `address_out`=0x00202, `bus_ben`=01, `data_out`[7:0]=0x12;
  - single `eu_done` afterwards.
- Fetch at odd 0x00011 with `readyb` high 3 clocks, `flush` pulsed in clock 2 → address held 4 clocks, `bus_ben`=10, no `pf_done`, back to IDLE.
- Reset asserted while `readyb` is held high in EU_CYC → IDLE next clock, status 4'hF, `eu_done` never pulses.

Source files
------------

// File: rtl/v30mz_pkg.sv
// Shared types for the v30mz bus control unit: EU bus commands, bus status
// codes and the bus arbiter state encoding.
package v30mz_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } bus_command_t;

    typedef logic [3:0] bus_status_t;

    localparam bus_status_t BS_IDLE  = 4'hF;
    localparam bus_status_t BS_FETCH = 4'b1000;
    localparam bus_status_t BS_READ  = 4'b1001;
    localparam bus_status_t BS_WRITE = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PF_CYC,
        ST_EU_CYC,
        ST_EU_HI
    } bau_state_t;

endpackage

// File: rtl/bus_lane_steer.sv
// Byte-lane steering for the 16-bit bus: lane enables, write replication and
// right-justification of read data.
module bus_lane_steer (
    input  logic        i_lane,
    input  logic        i_word,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_rdata,
    output logic [1:0]  o_ben,
    output logic [15:0] o_wdata,
    output logic [15:0] o_rdata
);

    always_comb begin
        o_ben   = 2'b00;
        o_wdata = 16'h0000;
        o_rdata = 16'h0000;
        if (i_word) begin
            o_ben   = 2'b11;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
        end else begin
            // A byte write drives both lanes so the memory picks whichever is enabled.
            o_ben   = i_lane ? 2'b10 : 2'b01;
            o_wdata = {i_wdata[7:0], i_wdata[7:0]};
            o_rdata = {8'h00, (i_lane ? i_rdata[15:8] : i_rdata[7:0])};
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the external 16-bit bus between prefetch and the execution unit,
// splitting odd EU words into two byte cycles and dropping flushed fetches.
module bus_arbiter
    import v30mz_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pf_req,
    input  logic [ADDR_W-1:0] pf_addr,
    output logic              pf_done,
    output logic [15:0]       pf_data,
    output logic              pf_byte,
    input  logic              flush,
    input  logic [1:0]        eu_cmd,
    input  logic [ADDR_W-1:0] eu_addr,
    input  logic              eu_word,
    input  logic [15:0]       eu_wdata,
    output logic              eu_done,
    output logic [15:0]       eu_rdata,
    output logic [ADDR_W-1:0] address_out,
    output logic [1:0]        bus_ben,
    output logic [15:0]       data_out,
    input  logic [15:0]       data_in,
    input  logic              readyb,
    output logic [3:0]        bus_status,
    output logic [1:0]        o_dbg_state
);

    bau_state_t        r_state;
    logic [ADDR_W-1:0] r_address;
    logic [1:0]        r_ben;
    logic [15:0]       r_data_out;
    bus_status_t       r_status;
    logic              r_lane;
    logic              r_word;
    logic              r_split;
    logic [7:0]        r_lo;
    logic [7:0]        r_wr_hi;
    logic              r_discard;
    logic              r_pf_done;
    logic [15:0]       r_pf_data;
    logic              r_pf_byte;
    logic              r_eu_done;
    logic [15:0]       r_eu_rdata;

    logic              w_idle;
    logic              w_st_lane;
    logic              w_st_word;
    logic [1:0]        w_st_ben;
    logic [15:0]       w_st_wdata;
    logic [15:0]       w_st_rdata;
    logic              w_pf_kill;

    // The steer serves the write path when launching from IDLE and the read path at completion.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_st_lane = w_idle ? eu_addr[0] : r_lane;
    assign w_st_word = w_idle ? (eu_word & ~eu_addr[0]) : r_word;
    assign w_pf_kill = r_discard | flush;

    bus_lane_steer u_steer (
        .i_lane  (w_st_lane),
        .i_word  (w_st_word),
        .i_wdata (eu_wdata),
        .i_rdata (data_in),
        .o_ben   (w_st_ben),
        .o_wdata (w_st_wdata),
        .o_rdata (w_st_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_address  <= '0;
            r_ben      <= 2'b00;
            r_data_out <= 16'h0000;
            r_status   <= BS_IDLE;
            r_lane     <= 1'b0;
            r_word     <= 1'b0;
            r_split    <= 1'b0;
            r_lo       <= 8'h00;
            r_wr_hi    <= 8'h00;
            r_discard  <= 1'b0;
            r_pf_done  <= 1'b0;
            r_pf_data  <= 16'h0000;
            r_pf_byte  <= 1'b0;
            r_eu_done  <= 1'b0;
            r_eu_rdata <= 16'h0000;
        end else begin
            r_pf_done <= 1'b0;
            r_pf_byte <= 1'b0;
            r_eu_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // eu_cmd is still held while eu_done pulses; do not restart that access.
                    if (eu_cmd != CMD_IDLE && !r_eu_done) begin
                        r_state    <= ST_EU_CYC;
                        r_address  <= eu_addr;
                        r_ben      <= w_st_ben;
                        r_data_out <= w_st_wdata;
                        r_status   <= (eu_cmd == CMD_WRITE) ? BS_WRITE : BS_READ;
                        r_lane     <= eu_addr[0];
                        r_word     <= eu_word & ~eu_addr[0];
                        r_split    <= eu_word & eu_addr[0];
                        r_wr_hi    <= eu_wdata[15:8];
                    end else if (pf_req && !flush) begin
                        r_state   <= ST_PF_CYC;
                        r_address <= pf_addr;
                        r_ben     <= pf_addr[0] ? 2'b10 : 2'b11;
                        r_status  <= BS_FETCH;
                        r_lane    <= pf_addr[0];
                    end
                end
                ST_PF_CYC: begin
                    if (!readyb) begin
                        r_state   <= ST_IDLE;
                        r_status  <= BS_IDLE;
                        r_ben     <= 2'b00;
                        r_pf_data <= data_in;
                        r_pf_done <= ~w_pf_kill;
                        r_pf_byte <= r_lane & ~w_pf_kill;
                        r_discard <= 1'b0;
                    end else if (flush) begin
                        r_discard <= 1'b1;
                    end
                end
                ST_EU_CYC: begin
                    if (!readyb) begin
                        if (r_split) begin
                            r_state    <= ST_EU_HI;
                            r_address  <= r_address + ADDR_W'(1);
                            r_ben      <= 2'b01;
                            r_data_out <= {r_wr_hi, r_wr_hi};
                            r_lo       <= data_in[15:8];
                            r_split    <= 1'b0;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_status   <= BS_IDLE;
                            r_ben      <= 2'b00;
                            r_eu_rdata <= w_st_rdata;
                            r_eu_done  <= 1'b1;
                        end
                    end
                end
                ST_EU_HI: begin
                    if (!readyb) begin
                        r_state    <= ST_IDLE;
                        r_status   <= BS_IDLE;
                        r_ben      <= 2'b00;
                        r_eu_rdata <= {data_in[7:0], r_lo};
                        r_eu_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_status <= BS_IDLE;
                    r_ben    <= 2'b00;
                end
            endcase
        end
    end

    // A flush arriving in the pulse clock still suppresses the stale fetch.
    assign pf_done     = r_pf_done & ~flush;
    assign pf_data     = r_pf_data;
    assign pf_byte     = r_pf_byte;
    assign eu_done     = r_eu_done;
    assign eu_rdata    = r_eu_rdata;
    assign address_out = r_address;
    assign bus_ben     = r_ben;
    assign data_out    = r_data_out;
    assign bus_status  = r_status;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random EU/prefetch traffic
// checked against a per-transaction bus-phase model.
module tb_bus_arbiter;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              pf_req;
    logic [ADDR_W-1:0] pf_addr;
    logic              pf_done;
    logic [15:0]       pf_data;
    logic              pf_byte;
    logic              flush;
    logic [1:0]        eu_cmd;
    logic [ADDR_W-1:0] eu_addr;
    logic              eu_word;
    logic [15:0]       eu_wdata;
    logic              eu_done;
    logic [15:0]       eu_rdata;
    logic [ADDR_W-1:0] address_out;
    logic [1:0]        bus_ben;
    logic [15:0]       data_out;
    logic [15:0]       data_in;
    logic              readyb;
    logic [3:0]        bus_status;
    logic [1:0]        o_dbg_state;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    bus_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pf_req      (pf_req),
        .pf_addr     (pf_addr),
        .pf_done     (pf_done),
        .pf_data     (pf_data),
        .pf_byte     (pf_byte),
        .flush       (flush),
        .eu_cmd      (eu_cmd),
        .eu_addr     (eu_addr),
        .eu_word     (eu_word),
        .eu_wdata    (eu_wdata),
        .eu_done     (eu_done),
        .eu_rdata    (eu_rdata),
        .address_out (address_out),
        .bus_ben     (bus_ben),
        .data_out    (data_out),
        .data_in     (data_in),
        .readyb      (readyb),
        .bus_status  (bus_status),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pf_req   = 1'b0;
        pf_addr  = '0;
        flush    = 1'b0;
        eu_cmd   = 2'd0;
        eu_addr  = '0;
        eu_word  = 1'b0;
        eu_wdata = 16'h0000;
        data_in  = 16'h0000;
        readyb   = 1'b1;
    endtask

    // ---------------- driver tasks with model ----------------
    // EU access: model lists the bus phases the access must produce.
    task automatic run_eu(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                          input logic word, input logic [15:0] wdata,
                          input int waits, input string tag);
        int nph;
        logic [ADDR_W-1:0] pa[2];
        logic [1:0]  pb[2];
        logic [15:0] pd[2];
        logic [15:0] pm[2];
        logic [15:0] din[2];
        logic [15:0] exp_r;
        logic [15:0] got;
        logic [3:0]  st;
        st = (cmd == 2'd2) ? 4'b1010 : 4'b1001;
        din[0] = 16'($urandom);
        din[1] = 16'($urandom);
        if (!word) begin
            nph = 1;
            pa[0] = addr; pb[0] = addr[0] ? 2'b10 : 2'b01;
            pd[0] = {wdata[7:0], wdata[7:0]}; pm[0] = 16'hFFFF;
            exp_r = addr[0] ? {8'h00, din[0][15:8]} : {8'h00, din[0][7:0]};
        end else if (!addr[0]) begin
            nph = 1;
            pa[0] = addr; pb[0] = 2'b11; pd[0] = wdata; pm[0] = 16'hFFFF;
            exp_r = din[0];
        end else begin
            nph = 2;
            pa[0] = addr; pb[0] = 2'b10; pd[0] = {wdata[7:0], 8'h00}; pm[0] = 16'hFF00;
            pa[1] = ADDR_W'((32'(addr) + 1) % (1 << ADDR_W));
            pb[1] = 2'b01; pd[1] = {8'h00, wdata[15:8]}; pm[1] = 16'h00FF;
            exp_r = {din[1][7:0], din[0][15:8]};
        end
        if (cmd == 2'd1) exp_q.push_back(exp_r);
        eu_cmd = cmd; eu_addr = addr; eu_word = word; eu_wdata = wdata; readyb = 1'b1;
        tick();
        for (int p = 0; p < nph; p++) begin
            for (int w = 0; w <= waits; w++) begin
                total++;
                if (address_out !== pa[p] || bus_ben !== pb[p] || bus_status !== st || eu_done !== 1'b0 ||
                    (cmd == 2'd2 && (data_out & pm[p]) !== pd[p])) begin
                    bad++;
                    $display("FAIL %s phase%0d cyc%0d: got addr=%h ben=%b st=%h dout=%h done=%b, want addr=%h ben=%b st=%h dout&%h=%h done=0",
                             tag, p, w, address_out, bus_ben, bus_status, data_out, eu_done, pa[p], pb[p], st, pm[p], pd[p]);
                end
                if (w == waits) begin
                    readyb = 1'b0;
                    data_in = din[p];
                end
                tick();
                readyb = 1'b1;
            end
        end
        total++;
        if (eu_done !== 1'b1 || bus_status !== 4'hF || bus_ben !== 2'b00) begin
            bad++;
            $display("FAIL %s done: got done=%b st=%h ben=%b, want done=1 st=f ben=00", tag, eu_done, bus_status, bus_ben);
        end
        if (cmd == 2'd1) begin
            got = eu_rdata;
            exp_r = exp_q.pop_front();
            total++;
            if (got !== exp_r) begin
                bad++;
                $display("FAIL %s rdata: got %h want %h", tag, got, exp_r);
            end
        end
        tick();
        eu_cmd = 2'd0;
        total++;
        if (eu_done !== 1'b0 || bus_status === 4'b1001 || bus_status === 4'b1010) begin
            bad++;
            $display("FAIL %s after: got done=%b st=%h, want single done and no EU restart", tag, eu_done, bus_status);
        end
    endtask

    // Prefetch: flush_cyc < 0 means no flush, otherwise the PF_CYC clock index it is raised in.
    task automatic run_pf(input logic [ADDR_W-1:0] addr, input int waits, input int flush_cyc,
                          input logic [15:0] din, input string tag);
        logic [1:0] eb;
        logic expect_done;
        eb = addr[0] ? 2'b10 : 2'b11;
        expect_done = (flush_cyc < 0);
        pf_req = 1'b1; pf_addr = addr; readyb = 1'b1;
        tick();
        pf_req = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            total++;
            if (address_out !== addr || bus_ben !== eb || bus_status !== 4'b1000 || pf_done !== 1'b0) begin
                bad++;
                $display("FAIL %s cyc%0d: got addr=%h ben=%b st=%h done=%b, want addr=%h ben=%b st=8 done=0",
                         tag, w, address_out, bus_ben, bus_status, pf_done, addr, eb);
            end
            flush = (w == flush_cyc);
            if (w == waits) begin
                readyb = 1'b0;
                data_in = din;
            end
            tick();
            readyb = 1'b1;
            flush = 1'b0;
        end
        total++;
        if (pf_done !== expect_done || bus_status !== 4'hF || bus_ben !== 2'b00) begin
            bad++;
            $display("FAIL %s done: got done=%b st=%h ben=%b, want done=%b st=f ben=00",
                     tag, pf_done, bus_status, bus_ben, expect_done);
        end
        if (expect_done) begin
            total++;
            if (pf_data !== din || pf_byte !== addr[0]) begin
                bad++;
                $display("FAIL %s data: got data=%h byte=%b, want data=%h byte=%b", tag, pf_data, pf_byte, din, addr[0]);
            end
        end
        tick();
        total++;
        if (pf_done !== 1'b0 || bus_status !== 4'hF) begin
            bad++;
            $display("FAIL %s after: got done=%b st=%h, want done=0 st=f", tag, pf_done, bus_status);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (bus_status !== 4'hF || bus_ben !== 2'b00 || address_out !== '0 || data_out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_bus: got st=%h ben=%b addr=%h dout=%h, want f 00 0 0", bus_status, bus_ben, address_out, data_out);
        end
        total++;
        if (pf_done !== 1'b0 || eu_done !== 1'b0 || pf_byte !== 1'b0 || pf_data !== 16'h0 || eu_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_out: got pfd=%b eud=%b pfb=%b pfdata=%h eudata=%h, want all 0",
                     pf_done, eu_done, pf_byte, pf_data, eu_rdata);
        end
    endtask

    task automatic test_first_fetch();
        run_pf(20'hFFFF0, 0, -1, 16'hEA90, "fetch_ffff0");
    endtask

    task automatic test_eu_priority();
        pf_req = 1'b1;
        pf_addr = 20'h00400;
        run_eu(2'd1, 20'h00100, 1'b1, 16'h0000, 0, "prio_eu");
        total++;
        if (bus_status !== 4'b1000 || address_out !== 20'h00400) begin
            bad++;
            $display("FAIL prio_fetch_start: got st=%h addr=%h, want st=8 addr=00400", bus_status, address_out);
        end
        pf_req = 1'b0;
        readyb = 1'b0;
        data_in = 16'h5A5A;
        tick();
        readyb = 1'b1;
        total++;
        if (pf_done !== 1'b1 || pf_data !== 16'h5A5A) begin
            bad++;
            $display("FAIL prio_fetch_done: got done=%b data=%h, want 1 5a5a", pf_done, pf_data);
        end
        tick();
    endtask

    task automatic test_odd_word();
        run_eu(2'd2, 20'h00201, 1'b1, 16'h1234, 0, "odd_write");
        run_eu(2'd1, 20'h00301, 1'b1, 16'h0000, 2, "odd_read_wait");
        run_eu(2'd1, 20'hFFFFF, 1'b1, 16'h0000, 1, "odd_read_wrap");
        run_eu(2'd2, 20'hFFFFF, 1'b1, 16'hBEEF, 0, "odd_write_wrap");
    endtask

    task automatic test_bytes();
        run_eu(2'd2, 20'h00010, 1'b0, 16'hFFA5, 0, "byte_wr_even");
        run_eu(2'd2, 20'h00011, 1'b0, 16'h003C, 1, "byte_wr_odd");
        run_eu(2'd1, 20'h00020, 1'b0, 16'h0000, 0, "byte_rd_even");
        run_eu(2'd1, 20'h00021, 1'b0, 16'h0000, 0, "byte_rd_odd");
    endtask

    task automatic test_flush();
        run_pf(20'h00011, 3, 1, 16'h1111, "flush_mid");
        run_pf(20'h00022, 1, 1, 16'h2222, "flush_last");
        run_pf(20'h00033, 0, -1, 16'h3333, "after_flush");
    endtask

    task automatic test_reset_mid();
        eu_cmd = 2'd1; eu_addr = 20'h00444; eu_word = 1'b1; readyb = 1'b1;
        tick();
        tick();
        total++;
        if (bus_status !== 4'b1001) begin
            bad++;
            $display("FAIL rst_mid_start: got st=%h want 9", bus_status);
        end
        reset = 1'b1;
        tick();
        total++;
        if (bus_status !== 4'hF || bus_ben !== 2'b00 || eu_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_abort: got st=%h ben=%b done=%b, want f 00 0", bus_status, bus_ben, eu_done);
        end
        reset = 1'b0;
        eu_cmd = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (eu_done !== 1'b0 || bus_status !== 4'hF) begin
                bad++;
                $display("FAIL rst_mid_quiet%0d: got done=%b st=%h, want 0 f", i, eu_done, bus_status);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            int waits;
            logic [ADDR_W-1:0] a;
            kind = $urandom_range(0, 2);
            waits = $urandom_range(0, 2);
            a = ADDR_W'($urandom);
            if (kind == 0) begin
                run_pf(a, waits, ($urandom_range(0, 3) == 0) ? $urandom_range(0, waits) : -1,
                       16'($urandom), $sformatf("rnd%0d_pf", i));
            end else begin
                run_eu(2'(kind), a, 1'($urandom_range(0, 1)), 16'($urandom), waits, $sformatf("rnd%0d_eu", i));
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_eu_priority();
        test_odd_word();
        test_bytes();
        test_flush();
        test_reset_mid();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
